// File: rtl/vga_timing_multi_if.sv
// Control and video-timing bundle between a timing generator (slave) and its
// controller/consumer (master).
interface vga_timing_multi_if #(
   parameter int CNT_W  = 11,
   parameter int FCNT_W = 16
);
   logic              en;
   logic [1:0]        mode_sel;
   logic [CNT_W-1:0]  hcount;
   logic [CNT_W-1:0]  vcount;
   logic              hsync;
   logic              vsync;
   logic              hblnk;
   logic              vblnk;
   logic              frame_start;
   logic [1:0]        mode_act;
   logic [FCNT_W-1:0] frame_cnt;

   modport master (
      output en, mode_sel,
      input  hcount, vcount, hsync, vsync, hblnk, vblnk, frame_start, mode_act, frame_cnt
   );

   modport slave (
      input  en, mode_sel,
      output hcount, vcount, hsync, vsync, hblnk, vblnk, frame_start, mode_act, frame_cnt
   );
endinterface

// File: rtl/vga_timing_multi.sv
// Multi-mode VGA timing generator: 800x600, 640x480 and 1024x768 selectable at
// runtime, switched only at the frame boundary, with frame strobe and counter.
module vga_timing_multi #(
   parameter int CNT_W        = 11,
   parameter int FCNT_W       = 16,
   parameter int DEFAULT_MODE = 0
) (
   input  logic              pclk,
   input  logic              rst,
   vga_timing_multi_if.slave vga
);

   typedef logic [CNT_W-1:0] cnt_t;

   typedef struct packed {
      cnt_t h_act;
      cnt_t h_sync_first;
      cnt_t h_sync_last;
      cnt_t h_last;
      cnt_t v_act;
      cnt_t v_sync_first;
      cnt_t v_sync_last;
      cnt_t v_last;
      logic sync_pos;
   } timing_t;

   localparam logic [1:0] RST_MODE = 2'(DEFAULT_MODE);
   localparam logic       RST_IDLE = (DEFAULT_MODE == 0) ? 1'b0 : 1'b1;

   // Builds the decode thresholds from the usual ACT/FP/SYNC/TOT description.
   function automatic timing_t mk_timing(
      input int ha, input int hf, input int hs, input int ht,
      input int va, input int vf, input int vs, input int vt,
      input logic pos
   );
      timing_t t;
      t.h_act        = cnt_t'(ha);
      t.h_sync_first = cnt_t'(ha + hf);
      t.h_sync_last  = cnt_t'(ha + hf + hs - 1);
      t.h_last       = cnt_t'(ht - 1);
      t.v_act        = cnt_t'(va);
      t.v_sync_first = cnt_t'(va + vf);
      t.v_sync_last  = cnt_t'(va + vf + vs - 1);
      t.v_last       = cnt_t'(vt - 1);
      t.sync_pos     = pos;
      return t;
   endfunction

   function automatic timing_t timing_of(input logic [1:0] mode);
      case (mode)
         2'd1:    return mk_timing(640,  16,  96,  800, 480, 10, 2, 525, 1'b0);
         2'd2:    return mk_timing(1024, 24, 136, 1344, 768,  3, 6, 806, 1'b0);
         default: return mk_timing(800,  40, 128, 1056, 600,  1, 4, 628, 1'b1);
      endcase
   endfunction

   function automatic logic in_range(input cnt_t c, input cnt_t lo, input cnt_t hi);
      return (c >= lo) && (c <= hi);
   endfunction

   cnt_t              hcount_q, hcount_d;
   cnt_t              vcount_q, vcount_d;
   logic [1:0]        mode_q, mode_d;
   logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic              hsync_q, hsync_d;
   logic              vsync_q, vsync_d;
   logic              hblnk_q, hblnk_d;
   logic              vblnk_q, vblnk_d;
   logic              frame_start_q, frame_start_d;

   timing_t cur_t, nxt_t;
   logic    h_end, v_end, boundary;

   // NOTE: every always_comb output gets a default first so no path leaves a latch.
   always_comb begin
      cur_t         = timing_of(mode_q);
      h_end         = (hcount_q == cur_t.h_last);
      v_end         = (vcount_q == cur_t.v_last);
      boundary      = h_end && v_end;

      hcount_d      = h_end ? '0 : hcount_q + cnt_t'(1);
      vcount_d      = vcount_q;
      if (h_end) begin
         vcount_d   = v_end ? '0 : vcount_q + cnt_t'(1);
      end

      mode_d        = mode_q;
      if (boundary) begin
         mode_d     = (vga.mode_sel == 2'd3) ? 2'd0 : vga.mode_sel;
      end

      // Flags are decoded from the next counts under the next mode so they
      // line up with hcount/vcount in the same cycle.
      nxt_t         = timing_of(mode_d);
      hsync_d       = in_range(hcount_d, nxt_t.h_sync_first, nxt_t.h_sync_last) ^ ~nxt_t.sync_pos;
      vsync_d       = in_range(vcount_d, nxt_t.v_sync_first, nxt_t.v_sync_last) ^ ~nxt_t.sync_pos;
      hblnk_d       = (hcount_d >= nxt_t.h_act);
      vblnk_d       = (vcount_d >= nxt_t.v_act);
      frame_start_d = boundary;
      frame_cnt_d   = frame_cnt_q + FCNT_W'(boundary);
   end

   // NOTE: sequential state uses non-blocking assignments so all registers
   // sample the same pre-edge values regardless of statement order.
   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         hcount_q      <= '0;
         vcount_q      <= '0;
         mode_q        <= RST_MODE;
         frame_cnt_q   <= '0;
         hsync_q       <= RST_IDLE;
         vsync_q       <= RST_IDLE;
         hblnk_q       <= 1'b0;
         vblnk_q       <= 1'b0;
         frame_start_q <= 1'b0;
      end else if (vga.en) begin
         hcount_q      <= hcount_d;
         vcount_q      <= vcount_d;
         mode_q        <= mode_d;
         frame_cnt_q   <= frame_cnt_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         hblnk_q       <= hblnk_d;
         vblnk_q       <= vblnk_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign vga.hcount      = hcount_q;
   assign vga.vcount      = vcount_q;
   assign vga.mode_act    = mode_q;
   assign vga.frame_cnt   = frame_cnt_q;
   assign vga.hsync       = hsync_q;
   assign vga.vsync       = vsync_q;
   assign vga.hblnk       = hblnk_q;
   assign vga.vblnk       = vblnk_q;
   assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_multi.sv
// Directed bench for vga_timing_multi; long stretches of a frame are skipped by
// forcing the counters to a chosen position just before a clock edge.
module tb_vga_timing_multi;

   logic pclk = 1'b0;
   logic rst  = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [10:0] jh, jv;

   vga_timing_multi_if #(.CNT_W(11), .FCNT_W(2)) vif ();

   vga_timing_multi #(.CNT_W(11), .FCNT_W(2), .DEFAULT_MODE(0)) dut (
      .pclk (pclk),
      .rst  (rst),
      .vga  (vif.slave)
   );

   always #5 pclk = ~pclk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge pclk);
   endtask

   // Place the counters at (h, v); the next rising edge advances from there.
   task jump(input int h, input int v);
      jh = 11'(h);
      jv = 11'(v);
      force dut.hcount_q = jh;
      force dut.vcount_q = jv;
      #1;
      release dut.hcount_q;
      release dut.vcount_q;
   endtask

   initial begin
      vif.en       = 1'b1;
      vif.mode_sel = 2'd0;
      @(negedge pclk);
      check("rst_hcount", 32'(vif.hcount), 0);
      check("rst_vcount", 32'(vif.vcount), 0);
      check("rst_hsync", 32'(vif.hsync), 0);
      check("rst_vsync", 32'(vif.vsync), 0);
      check("rst_hblnk", 32'(vif.hblnk), 0);
      check("rst_vblnk", 32'(vif.vblnk), 0);
      check("rst_fs", 32'(vif.frame_start), 0);
      check("rst_mode", 32'(vif.mode_act), 0);
      check("rst_fcnt", 32'(vif.frame_cnt), 0);
      rst = 1'b1;

      // Mode 0 line and frame timing
      tick(1);   check("m0_h1", 32'(vif.hcount), 1);
                 check("m0_fs_first", 32'(vif.frame_start), 0);
      tick(798); check("m0_hblnk799", 32'(vif.hblnk), 0);
      tick(1);   check("m0_h800", 32'(vif.hcount), 800);
                 check("m0_hblnk800", 32'(vif.hblnk), 1);
                 check("m0_hsync800", 32'(vif.hsync), 0);
      tick(39);  check("m0_hsync839", 32'(vif.hsync), 0);
      tick(1);   check("m0_hsync840", 32'(vif.hsync), 1);
      tick(127); check("m0_h967", 32'(vif.hcount), 967);
                 check("m0_hsync967", 32'(vif.hsync), 1);
      tick(1);   check("m0_hsync968", 32'(vif.hsync), 0);
      tick(87);  check("m0_h1055", 32'(vif.hcount), 1055);
                 check("m0_v0", 32'(vif.vcount), 0);
      tick(1);   check("m0_wrap_h", 32'(vif.hcount), 0);
                 check("m0_wrap_v", 32'(vif.vcount), 1);
                 check("m0_line_fs", 32'(vif.frame_start), 0);
      jump(1055, 599); tick(1);
                 check("m0_v600", 32'(vif.vcount), 600);
                 check("m0_vsync600", 32'(vif.vsync), 0);
                 check("m0_vblnk600", 32'(vif.vblnk), 1);
      jump(1055, 600); tick(1); check("m0_vsync601", 32'(vif.vsync), 1);
      jump(1055, 603); tick(1); check("m0_vsync604", 32'(vif.vsync), 1);
      jump(1055, 604); tick(1); check("m0_vsync605", 32'(vif.vsync), 0);
      jump(1054, 627); tick(1);
                 check("m0_last_h", 32'(vif.hcount), 1055);
                 check("m0_last_fs", 32'(vif.frame_start), 0);
      tick(1);   check("f1_h", 32'(vif.hcount), 0);
                 check("f1_v", 32'(vif.vcount), 0);
                 check("f1_fs", 32'(vif.frame_start), 1);
                 check("f1_fcnt", 32'(vif.frame_cnt), 1);
                 check("f1_vblnk", 32'(vif.vblnk), 0);
                 check("f1_hblnk", 32'(vif.hblnk), 0);
      tick(1);   check("f1_fs_clear", 32'(vif.frame_start), 0);

      // Request mode 1 mid-frame
      vif.mode_sel = 2'd1;
      tick(5);   check("m1_pending", 32'(vif.mode_act), 0);
      jump(1054, 627); tick(1);
                 check("m1_bnd_mode", 32'(vif.mode_act), 0);
                 check("m1_bnd_hsync", 32'(vif.hsync), 0);
      tick(1);   check("m1_mode", 32'(vif.mode_act), 1);
                 check("m1_hsync_idle", 32'(vif.hsync), 1);
                 check("m1_vsync_idle", 32'(vif.vsync), 1);
                 check("m1_fs", 32'(vif.frame_start), 1);
                 check("m1_fcnt", 32'(vif.frame_cnt), 2);
      tick(655); check("m1_hsync655", 32'(vif.hsync), 1);
      tick(1);   check("m1_hsync656", 32'(vif.hsync), 0);
      tick(95);  check("m1_hsync751", 32'(vif.hsync), 0);
      tick(1);   check("m1_hsync752", 32'(vif.hsync), 1);
                 check("m1_hblnk752", 32'(vif.hblnk), 1);
      tick(47);  check("m1_h799", 32'(vif.hcount), 799);
      tick(1);   check("m1_wrap_h", 32'(vif.hcount), 0);
                 check("m1_wrap_v", 32'(vif.vcount), 1);
      jump(799, 488); tick(1); check("m1_vsync489", 32'(vif.vsync), 1);
      jump(799, 489); tick(1);
                 check("m1_vsync490", 32'(vif.vsync), 0);
                 check("m1_vblnk490", 32'(vif.vblnk), 1);
      jump(798, 524); tick(2);
                 check("m1_vwrap", 32'(vif.vcount), 0);
                 check("m1_f_fs", 32'(vif.frame_start), 1);
                 check("m1_f_fcnt", 32'(vif.frame_cnt), 3);

      // Mode 2, then reserved 3 falls back to 0
      vif.mode_sel = 2'd2;
      tick(3);   check("m2_pending", 32'(vif.mode_act), 1);
      jump(798, 524); tick(2);
                 check("m2_mode", 32'(vif.mode_act), 2);
                 check("m2_fcnt_wrap", 32'(vif.frame_cnt), 0);
                 check("m2_hsync_idle", 32'(vif.hsync), 1);
      tick(1);   check("m2_fs_clear", 32'(vif.frame_start), 0);
      jump(1342, 5); tick(1);
                 check("m2_h1343", 32'(vif.hcount), 1343);
                 check("m2_hblnk", 32'(vif.hblnk), 1);
      tick(1);   check("m2_wrap_h", 32'(vif.hcount), 0);
                 check("m2_wrap_v", 32'(vif.vcount), 6);
      jump(1343, 770); tick(1); check("m2_vsync771", 32'(vif.vsync), 0);
      jump(1343, 775); tick(1); check("m2_vsync776", 32'(vif.vsync), 0);
      jump(1343, 776); tick(1); check("m2_vsync777", 32'(vif.vsync), 1);
      jump(1046, 10);  tick(1); check("m2_hsync1047", 32'(vif.hsync), 1);
      tick(1);   check("m2_hsync1048", 32'(vif.hsync), 0);
      vif.mode_sel = 2'd3;
      jump(1342, 805); tick(1);
                 check("m3_bnd_mode", 32'(vif.mode_act), 2);
      tick(1);   check("m3_mode", 32'(vif.mode_act), 0);
                 check("m3_hsync", 32'(vif.hsync), 0);
                 check("m3_vsync", 32'(vif.vsync), 0);
                 check("m3_fs", 32'(vif.frame_start), 1);
                 check("m3_fcnt", 32'(vif.frame_cnt), 1);

      // Freeze mid-line
      tick(500); check("en_h500", 32'(vif.hcount), 500);
      vif.en = 1'b0;
      tick(10);  check("en_hold_h", 32'(vif.hcount), 500);
                 check("en_hold_v", 32'(vif.vcount), 0);
                 check("en_hold_hblnk", 32'(vif.hblnk), 0);
                 check("en_hold_fcnt", 32'(vif.frame_cnt), 1);
      vif.en = 1'b1;
      tick(1);   check("en_resume", 32'(vif.hcount), 501);

      // Freeze on the boundary cycle
      jump(1054, 627); tick(1);
      vif.en = 1'b0;
      vif.mode_sel = 2'd1;
      tick(3);   check("bfrz_h", 32'(vif.hcount), 1055);
                 check("bfrz_v", 32'(vif.vcount), 627);
                 check("bfrz_mode", 32'(vif.mode_act), 0);
                 check("bfrz_fcnt", 32'(vif.frame_cnt), 1);
      vif.mode_sel = 2'd2;
      vif.en = 1'b1;
      tick(1);   check("bfrz_wrap_mode", 32'(vif.mode_act), 2);
                 check("bfrz_wrap_fcnt", 32'(vif.frame_cnt), 2);
                 check("bfrz_wrap_fs", 32'(vif.frame_start), 1);
      vif.en = 1'b0;
      tick(4);   check("fs_hold", 32'(vif.frame_start), 1);
                 check("fs_hold_h", 32'(vif.hcount), 0);
      vif.en = 1'b1;
      tick(1);   check("fs_release", 32'(vif.frame_start), 0);
                 check("fs_release_h", 32'(vif.hcount), 1);

      // Asynchronous reset mid-line
      vif.mode_sel = 2'd0;
      jump(1342, 805); tick(2);
                 check("pre_rst_mode", 32'(vif.mode_act), 0);
                 check("pre_rst_fcnt", 32'(vif.frame_cnt), 3);
      jump(899, 300); tick(1);
                 check("pre_rst_h", 32'(vif.hcount), 900);
                 check("pre_rst_hsync", 32'(vif.hsync), 1);
                 check("pre_rst_hblnk", 32'(vif.hblnk), 1);
      #2 rst = 1'b0;
      #1;
      check("arst_h", 32'(vif.hcount), 0);
      check("arst_v", 32'(vif.vcount), 0);
      check("arst_hsync", 32'(vif.hsync), 0);
      check("arst_vsync", 32'(vif.vsync), 0);
      check("arst_hblnk", 32'(vif.hblnk), 0);
      check("arst_vblnk", 32'(vif.vblnk), 0);
      check("arst_fs", 32'(vif.frame_start), 0);
      check("arst_fcnt", 32'(vif.frame_cnt), 0);
      check("arst_mode", 32'(vif.mode_act), 0);
      @(negedge pclk);
      rst = 1'b1;
      tick(1);   check("post_rst_h", 32'(vif.hcount), 1);
                 check("post_rst_fs", 32'(vif.frame_start), 0);
      jump(1054, 627); tick(1);
                 check("post_rst_last_fs", 32'(vif.frame_start), 0);
      tick(1);   check("post_rst_wrap_fs", 32'(vif.frame_start), 1);
                 check("post_rst_wrap_fcnt", 32'(vif.frame_cnt), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
